// File: rtl/jt1943_prom_loader.sv
// Palette PROM download sequencer: ioctl byte stream -> setup/strobe writes into PROMs 12A/13A/14A/12C.
// Optional JT1943_PROM_CLEAR_EN: zero-fill all four PROMs at the start of each download.
module jt1943_prom_loader #(
    parameter logic [21:0] PROM_START = 22'h38000,
    parameter int          WE_LEN     = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [7:0]  prog_addr,
    output logic [3:0]  prom_din,
    output logic        prom_12a_we,
    output logic        prom_13a_we,
    output logic        prom_14a_we,
    output logic        prom_12c_we,
    output logic        busy,
    output logic        overflow,
    output logic        prom_ok
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
`ifdef JT1943_PROM_CLEAR_EN
    localparam logic [2:0] S_CLEAR  = 3'd3;
    localparam logic [2:0] S_CLR_WE = 3'd4;
`endif
    localparam logic [3:0] WE_INIT  = 4'(WE_LEN);

    logic [2:0]  state;
    logic [3:0]  we_cnt;
    logic [1:0]  region;
    logic [3:0]  we;
    logic        buf_full;
    logic [7:0]  buf_addr;
    logic [3:0]  buf_data;
    logic [1:0]  buf_region;
    logic        dl_q;
    logic [10:0] count;
    logic [22:0] addr_ext;
    logic [9:0]  off;
    logic        in_range, accept, pop, store, dl_rise, dl_fall, clr_start;
    logic        unused_bits;

    assign unused_bits = ^ioctl_data[7:4];
    assign addr_ext    = {1'b0, ioctl_addr};
    assign in_range    = (addr_ext >= {1'b0, PROM_START}) &&
                         (addr_ext <  {1'b0, PROM_START} + 23'd1024);
    assign accept      = ioctl_wr && downloading && in_range;
    // Region is 1024 bytes, so the low 10 bits of the difference are the full offset
    assign off         = ioctl_addr[9:0] - PROM_START[9:0];
    assign dl_rise     = downloading && !dl_q;
    assign dl_fall     = !downloading && dl_q;
`ifdef JT1943_PROM_CLEAR_EN
    assign clr_start   = dl_rise;
`else
    assign clr_start   = 1'b0;
`endif
    // A clear start takes priority over a pop, so the buffered byte waits for the clear
    assign pop         = (state == S_IDLE) && buf_full && !clr_start;
    // A pop frees the slot in the same cycle, so a simultaneous accept is not dropped
    assign store       = accept && (!buf_full || pop);
    assign busy        = (state != S_IDLE) || buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full   <= 1'b0;
            buf_addr   <= 8'd0;
            buf_data   <= 4'd0;
            buf_region <= 2'd0;
        end else if (store) begin
            buf_full   <= 1'b1;
            buf_addr   <= off[7:0];
            buf_data   <= ioctl_data[3:0];
            buf_region <= off[9:8];
        end else if (pop) begin
            buf_full   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            we_cnt    <= 4'd0;
            region    <= 2'd0;
            prog_addr <= 8'd0;
            prom_din  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    prog_addr <= buf_addr;
                    prom_din  <= buf_data;
                    region    <= buf_region;
                    state     <= S_SETUP;
                end
                S_SETUP: begin
                    state  <= S_STROBE;
                    we_cnt <= WE_INIT;
                end
                S_STROBE: begin
                    if (we_cnt == 4'd1) state <= S_IDLE;
                    else                we_cnt <= we_cnt - 4'd1;
                end
`ifdef JT1943_PROM_CLEAR_EN
                S_CLEAR: begin
                    state  <= S_CLR_WE;
                    we_cnt <= WE_INIT;
                end
                S_CLR_WE: begin
                    if (we_cnt == 4'd1) begin
                        if (prog_addr == 8'hFF) state <= S_IDLE;
                        else begin
                            prog_addr <= prog_addr + 8'd1;
                            state     <= S_CLEAR;
                        end
                    end else begin
                        we_cnt <= we_cnt - 4'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
`ifdef JT1943_PROM_CLEAR_EN
            if (clr_start) begin
                state     <= S_CLEAR;
                prog_addr <= 8'd0;
                prom_din  <= 4'd0;
            end
`endif
        end
    end

    always_comb begin
        we = 4'b0;
        if (state == S_STROBE) we = 4'b0001 << region;
`ifdef JT1943_PROM_CLEAR_EN
        if (state == S_CLR_WE) we = 4'hF;
`endif
    end

    assign prom_12a_we = we[0];
    assign prom_13a_we = we[1];
    assign prom_14a_we = we[2];
    assign prom_12c_we = we[3];

    // Dropped bytes still count, so an overflowed download can never report prom_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q     <= 1'b0;
            count    <= 11'd0;
            overflow <= 1'b0;
            prom_ok  <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (dl_rise) begin
                count    <= accept ? 11'd1 : 11'd0;
                overflow <= accept && !store;
                prom_ok  <= 1'b0;
            end else begin
                if (accept && count != 11'h7FF) count <= count + 11'd1;
                if (accept && !store)           overflow <= 1'b1;
                if (dl_fall)                    prom_ok <= (count == 11'd1024) && !overflow;
            end
        end
    end

endmodule

// File: tb/tb_jt1943_prom_loader.sv
// Bench for jt1943_prom_loader: per-cycle schedule model plus directed literal checks and random traffic.
module tb_jt1943_prom_loader;
    localparam logic [21:0] PS = 22'h38000;
    localparam int WL = 1;
`ifdef JT1943_PROM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk = 0, rst = 1, rst4 = 1, downloading = 0, ioctl_wr = 0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [7:0]  prog_addr, prog_addr4;
    logic [3:0]  prom_din, prom_din4;
    logic        w12a, w13a, w14a, w12c, w12a4, w13a4, w14a4, w12c4;
    logic        busy, overflow, prom_ok, busy4, overflow4, prom_ok4;
    logic [3:0]  we, we4;

    assign we  = {w12c, w14a, w13a, w12a};
    assign we4 = {w12c4, w14a4, w13a4, w12a4};

    jt1943_prom_loader #(.PROM_START(PS), .WE_LEN(WL)) u_dut (
        .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr), .prom_din(prom_din),
        .prom_12a_we(w12a), .prom_13a_we(w13a), .prom_14a_we(w14a), .prom_12c_we(w12c),
        .busy(busy), .overflow(overflow), .prom_ok(prom_ok));

    jt1943_prom_loader #(.PROM_START(PS), .WE_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst4), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr4), .prom_din(prom_din4),
        .prom_12a_we(w12a4), .prom_13a_we(w13a4), .prom_14a_we(w14a4), .prom_12c_we(w12c4),
        .busy(busy4), .overflow(overflow4), .prom_ok(prom_ok4));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int nw[4];
    logic [3:0] mem[4][256];
    logic [7:0] golden[1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Record what the DUT actually writes into each PROM
    initial forever begin
        @(negedge clk);
        if (!rst)
            for (int r = 0; r < 4; r++)
                if (we[r]) begin
                    mem[r][prog_addr] = prom_din;
                    nw[r]++;
                end
    end

    // Schedule model: a popped byte at cycle P shows its address from P+1 and its WE
    // over P+2..P+1+WL; the FSM is free again at P+2+WL.
    initial begin : model
        int cyc, pop_c, free_c, clr_s, clr_e, mcnt, k;
        bit bv, dlp, movf, mok, rise, fall, clr, acc, pop, drop;
        logic [1:0] br, cr;
        logic [7:0] ba, ca, e_addr;
        logic [3:0] bd, cd, e_din, e_we;
        logic [21:0] off;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pop_c = -1000; free_c = 0; clr_s = -1; clr_e = -1; mcnt = 0;
                bv = 0; dlp = 0; movf = 0; mok = 0;
                br = 0; ba = 0; bd = 0; cr = 0; ca = 0; cd = 0;
                chk("rst we", we, 4'h0);
                chk("rst addr", prog_addr, 8'h00);
                chk("rst din", prom_din, 4'h0);
                chk("rst busy", busy, 1'b0);
                chk("rst ovf", overflow, 1'b0);
                chk("rst ok", prom_ok, 1'b0);
                continue;
            end
            if (clr_s >= 0 && cyc >= clr_s && cyc < clr_e) begin
                k = cyc - clr_s;
                e_addr = 8'(k / (1 + WL));
                e_din  = 4'h0;
                e_we   = (k % (1 + WL) != 0) ? 4'hF : 4'h0;
            end else begin
                e_addr = ca;
                e_din  = cd;
                e_we   = (cyc >= pop_c + 2 && cyc <= pop_c + 1 + WL) ? (4'b0001 << cr) : 4'h0;
            end
            chk("we", we, e_we);
            chk("prog_addr", prog_addr, e_addr);
            chk("prom_din", prom_din, e_din);
            chk("busy", busy, bv || (cyc < free_c));
            chk("overflow", overflow, movf);
            chk("prom_ok", prom_ok, mok);

            rise = downloading && !dlp;
            fall = !downloading && dlp;
            clr  = CLR_EN && rise;
            acc  = ioctl_wr && downloading && int'(ioctl_addr) >= int'(PS) &&
                   int'(ioctl_addr) < int'(PS) + 1024;
            pop  = bv && cyc >= free_c && !clr;
            if (pop) begin
                pop_c = cyc; cr = br; ca = ba; cd = bd; free_c = cyc + 2 + WL;
            end
            if (clr) begin
                clr_s = cyc + 1; clr_e = clr_s + 256 * (1 + WL); free_c = clr_e;
                pop_c = -1000; ca = 8'hFF; cd = 4'h0;
            end
            drop = acc && bv && !pop;
            if (acc && !drop) begin
                off = ioctl_addr - PS;
                bv = 1; br = off[9:8]; ba = off[7:0]; bd = ioctl_data[3:0];
            end else if (pop) begin
                bv = 0;
            end
            if (rise) begin
                mcnt = acc ? 1 : 0; movf = drop; mok = 0;
            end else begin
                if (acc && mcnt < 2047) mcnt++;
                if (drop) movf = 1;
                if (fall) mok = (mcnt == 1024) && !movf;
            end
            dlp = downloading;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [21:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1;
        @(posedge clk); #1;
        ioctl_wr = 0;
    endtask

    task automatic start_dl();
        @(posedge clk); #1;
        downloading = 1;
`ifdef JT1943_PROM_CLEAR_EN
        begin
            int n = 0;
            @(negedge clk); @(negedge clk);
            while (busy && n < 2000) begin n++; @(negedge clk); end
            chk("clear cycles", n, 256 * (1 + WL));
        end
`endif
    endtask

    task automatic end_dl(input logic e_ok, input logic e_ovf, input string nm);
        idle(8);
        downloading = 0;
        @(negedge clk); @(negedge clk);
        chk({nm, " prom_ok"}, prom_ok, e_ok);
        chk({nm, " overflow"}, overflow, e_ovf);
    endtask

    task automatic lit_write(input logic [9:0] o, input logic [7:0] d, input logic [3:0] ewe,
                             input logic [7:0] ea, input logic [3:0] ed, input string nm);
        drive_byte(PS + 22'(o), d);
        @(negedge clk); @(negedge clk);
        chk({nm, " we N+2"}, we, 4'h0);
        @(negedge clk);
        chk({nm, " we N+3"}, we, ewe);
        chk({nm, " addr N+3"}, prog_addr, ea);
        chk({nm, " din N+3"}, prom_din, ed);
        @(negedge clk);
        chk({nm, " we N+4"}, we, 4'h0);
        chk({nm, " addr hold"}, prog_addr, ea);
    endtask

    initial begin
        for (int r = 0; r < 4; r++) nw[r] = 0;
        repeat (3) @(negedge clk);
        chk("reset busy4", busy4, 1'b0);
        @(posedge clk); #1;
        rst = 0; rst4 = 0;

        start_dl();
        lit_write(10'h105, 8'hA7, 4'b0010, 8'h05, 4'h7, "single");
        lit_write(10'h000, 8'h5B, 4'b0001, 8'h00, 4'hB, "off000");
        lit_write(10'h1FF, 8'h0C, 4'b0010, 8'hFF, 4'hC, "off1FF");
        lit_write(10'h2FF, 8'hF3, 4'b0100, 8'hFF, 4'h3, "off2FF");
        lit_write(10'h300, 8'h19, 4'b1000, 8'h00, 4'h9, "off300");

        drive_byte(22'h37FFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("oor low busy", busy, 1'b0);
            chk("oor low we", we, 4'h0);
        end
        drive_byte(22'h38400, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("oor high busy", busy, 1'b0);
            chk("oor high we", we, 4'h0);
        end
        end_dl(1'b0, 1'b0, "partial");

        // Full download, 4-cycle spacing
        start_dl();
        for (int r = 0; r < 4; r++) nw[r] = 0;
        for (int i = 0; i < 1024; i++) begin
            golden[i] = 8'($urandom);
            drive_byte(PS + 22'(i), golden[i]);
            idle(2);
        end
        end_dl(1'b1, 1'b0, "full");
        for (int r = 0; r < 4; r++) chk($sformatf("writes prom%0d", r), nw[r], 256);
        begin
            int bad = 0;
            for (int i = 0; i < 1024; i++)
                if (mem[i / 256][i % 256] !== golden[i][3:0]) bad++;
            chk("prom contents", bad, 0);
        end

        // Three back-to-back bytes: third is dropped
        start_dl();
        for (int r = 0; r < 4; r++) nw[r] = 0;
        @(posedge clk); #1;
        ioctl_wr = 1; ioctl_addr = PS;      ioctl_data = 8'h01;
        @(posedge clk); #1;
        ioctl_addr = PS + 22'd1; ioctl_data = 8'h02;
        @(posedge clk); #1;
        ioctl_addr = PS + 22'd2; ioctl_data = 8'h03;
        @(posedge clk); #1;
        ioctl_wr = 0;
        idle(8);
        chk("burst writes", nw[0] + nw[1] + nw[2] + nw[3], 2);
        chk("burst byte0", mem[0][0], 4'h1);
        chk("burst byte1", mem[0][1], 4'h2);
        chk("burst overflow", overflow, 1'b1);
        for (int i = 3; i < 1024; i++) begin
            drive_byte(PS + 22'(i), 8'($urandom));
            idle(2);
        end
        end_dl(1'b0, 1'b1, "overflowed");

        // Random traffic around the region boundaries, with download toggles and resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) downloading = !downloading;
            ioctl_wr   = ($urandom_range(0, 2) == 0);
            ioctl_data = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       ioctl_addr = PS - 22'd1;
                1:       ioctl_addr = PS + 22'd1024;
                2:       ioctl_addr = 22'($urandom);
                default: ioctl_addr = PS + 22'($urandom_range(0, 1023));
            endcase
        end
        @(posedge clk); #1;
        rst = 0; ioctl_wr = 0; downloading = 1;
        idle(4);

        // Reset in the second WE cycle of a WE_LEN=4 write
        rst4 = 1;
        idle(1);
        rst4 = 0;
        begin
            int n = 0;
            @(negedge clk); @(negedge clk);
            while (busy4 && n < 3000) begin n++; @(negedge clk); end
            chk("dut4 idle before test", busy4, 1'b0);
        end
        drive_byte(PS + 22'h205, 8'h3C);
        @(negedge clk); @(negedge clk);
        chk("we4 N+2", we4, 4'h0);
        @(negedge clk);
        chk("we4 N+3", we4, 4'b0100);
        chk("addr4 N+3", prog_addr4, 8'h05);
        @(posedge clk); #1;
        chk("we4 N+4", we4, 4'b0100);
        #1 rst4 = 1;
        #1;
        chk("we4 after rst", we4, 4'h0);
        chk("busy4 after rst", busy4, 1'b0);
        chk("addr4 after rst", prog_addr4, 8'h00);
        @(posedge clk); #1;
        rst4 = 0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jt1943_prom_loader.md
Name: jt1943_prom_loader

Overview:
- Sequences the download-time programming of the four colour-mixer palette PROMs: red 12A, green 13A, blue 14A and layer-select 12C.
- Sits between the ROM downloader (ioctl byte stream) and the colour mixer's prog_addr / prom_din / prom_*_we inputs.
- Decodes the PROM region, buffers one pending byte and generates a setup-then-strobe write sequence.
- Reports download completeness and buffer overflow.

Parameters:
- PROM_START, 22'h38000, ioctl byte address of PROM 12A entry 0. The region is 1024 bytes, in the order 12A, 13A, 14A, 12C, 256 bytes each.
- WE_LEN, 1, number of clk cycles the write enable stays high (valid range 1-15).

Ports:
- clk  input  1  system clock (24 MHz)
- rst  input  1  asynchronous reset, active-high
- downloading  input  1  high while the ROM download is in progress
- ioctl_addr  input  22  downloader byte address
- ioctl_data  input  8  downloader byte; only bits [3:0] are used
- ioctl_wr  input  1  one-cycle byte strobe
- prog_addr  output  8  PROM write address
- prom_din  output  4  PROM write data
- prom_12a_we  output  1  red PROM write enable
- prom_13a_we  output  1  green PROM write enable
- prom_14a_we  output  1  blue PROM write enable
- prom_12c_we  output  1  select PROM write enable
- busy  output  1  write sequence in progress or buffer occupied
- overflow  output  1  sticky; a byte was dropped
- prom_ok  output  1  last download delivered exactly 1024 PROM bytes

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, buffer empty, byte counter 0.
- Accept rule: a byte is accepted when ioctl_wr && downloading && PROM_START <= ioctl_addr < PROM_START+1024.
  - Captured fields: off = ioctl_addr - PROM_START (10 bits), region = off[9:8], addr = off[7:0], data = ioctl_data[3:0].
  - Bytes that fail the accept rule are ignored completely.
- Skid buffer: 1 entry.
  - An accepted byte is written into the buffer when the buffer is empty.
  - If the buffer is full, the byte is dropped and overflow is set. overflow stays set until reset or the next rising edge of downloading.
- FSM states: IDLE, SETUP, STROBE.
  - IDLE: if the buffer is full, pop it into the output registers (prog_addr, prom_din, region) and go to SETUP. All WEs are low.
  - SETUP: one cycle with address and data stable and WEs low, then go to STROBE and load the WE counter with WE_LEN.
  - STROBE: the WE selected by region is high (00→12a, 01→13a, 10→14a, 11→12c) and all others are low. When the counter reaches 1, go to IDLE.
  - prog_addr and prom_din hold their values through STROBE and the cycle after it.
- Latency and throughput:
  - Accepted ioctl_wr at cycle N: buffer full at N+1, SETUP at N+2, WE high from N+3 to N+2+WE_LEN.
  - Minimum spacing between bytes with no overflow is 2+WE_LEN cycles.
  - An accept on the same cycle the FSM pops the buffer counts as buffer-empty and is not dropped.
- busy = (state != IDLE) || buffer full.
- Byte counter: 11 bits, cleared on the rising edge of downloading, incremented per accepted byte (dropped bytes included), saturates at 2047.
- prom_ok:
  - Cleared on the rising edge of downloading.
  - On the falling edge of downloading, latched to (count == 1024) && !overflow.
- Download ending mid-sequence: the in-flight write and any buffered byte still complete. downloading only gates acceptance.
- Reset asserted mid-strobe: WE drops immediately (asynchronous); the buffered byte is lost.

Optional Feature:
- Macro JT1943_PROM_CLEAR_EN.
- When defined, the rising edge of downloading enters state CLEAR.
  - All four WEs pulse simultaneously with prom_din = 0 for prog_addr = 0..255.
  - Each address takes 1+WE_LEN cycles.
  - busy is high throughout.
  - Bytes accepted during CLEAR go to the skid buffer under normal overflow rules. The buffer is serviced only after CLEAR finishes (addr 255 done → IDLE).
- When not defined, there is no CLEAR state, and the rising edge of downloading only resets the counter, overflow and prom_ok.

Test Plan:
- Single write, WE_LEN=1: ioctl_addr=22'h38105, data=8'hA7 → prog_addr=8'h05, prom_din=4'h7, prom_13a_we high exactly 1 cycle at N+3; other WEs stay low.
- Region decode: bytes at offsets 0x000, 0x1FF, 0x2FF, 0x300 → WE on 12a, 13a, 14a, 12c respectively, with prog_addr 00, FF, FF, 00.
- Full download: 1024 bytes spaced 4 cycles apart, then downloading falls → prom_ok=1, overflow=0, each PROM receives 256 writes.
- Overflow: three accepted bytes on consecutive cycles → the first two are written, the third is dropped, overflow=1, and prom_ok=0 after download end even when count reaches 1024.
- Out of range: ioctl_addr=22'h37FFF and 22'h38400 → no WE, busy stays 0, count unchanged.
- Reset mid-strobe with WE_LEN=4: assert rst in the second WE cycle → all WEs and busy go to 0 within the same cycle. With JT1943_PROM_CLEAR_EN defined, a new download first performs 256 zero writes taking 512 cycles at WE_LEN=1.
